// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A between two clients, with read-data return.
// Define DPRAM_ARB_CLEAR_EN to zero-fill the RAM after reset before serving clients.
module dpram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_write,
    input  logic [DATA_W-1:0] ram_read,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;       // client served last: 0 = r0, 1 = r1
    logic   tag_vld_q, tag_vld_d;
    logic   tag_cli_q, tag_cli_d;
`ifdef DPRAM_ARB_CLEAR_EN
    logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            last_q    <= 1'b1;
            tag_vld_q <= 1'b0;
            tag_cli_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            tag_vld_q <= tag_vld_d;
            tag_cli_q <= tag_cli_d;
        end
    end

`ifdef DPRAM_ARB_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        tag_vld_d = 1'b0;
        tag_cli_d = tag_cli_q;
        r0_gnt    = 1'b0;
        r1_gnt    = 1'b0;
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_write = '0;
`ifdef DPRAM_ARB_CLEAR_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_RST: begin
`ifdef DPRAM_ARB_CLEAR_EN
                state_d = ST_CLEAR;
`else
                state_d = ST_RUN;
`endif
            end
`ifdef DPRAM_ARB_CLEAR_EN
            ST_CLEAR: begin
                ram_ce   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                // r0 wins a tie only when r1 was the one served last
                if (r0_req && (!r1_req || last_q)) begin
                    r0_gnt    = 1'b1;
                    ram_ce    = 1'b1;
                    ram_we    = r0_we;
                    ram_addr  = r0_addr;
                    ram_write = r0_wdata;
                    last_d    = 1'b0;
                    tag_vld_d = !r0_we;
                    tag_cli_d = 1'b0;
                end else if (r1_req) begin
                    r1_gnt    = 1'b1;
                    ram_ce    = 1'b1;
                    ram_we    = r1_we;
                    ram_addr  = r1_addr;
                    ram_write = r1_wdata;
                    last_d    = 1'b1;
                    tag_vld_d = !r1_we;
                    tag_cli_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign busy      = (state_q != ST_RUN);
    assign r0_rvalid = tag_vld_q & ~tag_cli_q;
    assign r1_rvalid = tag_vld_q &  tag_cli_q;
    assign r0_rdata  = r0_rvalid ? ram_read : '0;
    assign r1_rdata  = r1_rvalid ? ram_read : '0;

endmodule

// File: doc/dpram_port_arbiter.md
# dpram_port_arbiter

Two-requester arbiter that shares port A of the `dpram_r2w1_wt` dual-port RAM between two internal clients, one access per cycle, with round-robin fairness. It also returns read data to the client that issued the read. It sits directly in front of the RAM port; port B stays dedicated to its own user. An optional post-reset clear engine zero-fills the RAM before any client is served.

## Interface
- `ADDR_W`, 12, RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 16, RAM data width.

- `clk`  in  1  single clock; also drives the RAM's `a_clk`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `r0_req`, `r1_req`  in  1  each  access request; held until granted or withdrawn.
- `r0_we`, `r1_we`  in  1  each  1 = write, 0 = read.
- `r0_addr`, `r1_addr`  in  ADDR_W each  access address.
- `r0_wdata`, `r1_wdata`  in  DATA_W each  write data.
- `r0_gnt`, `r1_gnt`  out  1 each  access issued this cycle.
- `r0_rvalid`, `r1_rvalid`  out  1 each  read data valid for that client.
- `r0_rdata`, `r1_rdata`  out  DATA_W each  read data.
- `ram_ce`, `ram_we`  out  1 each  to RAM `a_ce` and `a_we`.
- `ram_addr`  out  ADDR_W  to RAM `a_addr`.
- `ram_write`  out  DATA_W  to RAM `a_write`.
- `ram_read`  in  DATA_W  from RAM `a_read`, synchronous read with 1-cycle latency.
- `busy`  out  1  high while not yet serving clients (reset/clear).

## Operation
- States: `RST` (post-reset), `CLEAR` (only with the macro), `RUN`. Asynchronous reset forces `RST`.
- `RST` → `CLEAR` or `RUN` on the first clock after `rst_n` deasserts.
- In `RUN`, winner selection is combinational each cycle:
  - only one `req` high → that client wins.
  - both high → the client not served last wins.
  - the last-served pointer updates on every grant; its reset value is r1, so r0 wins the first tie.
- Winner outputs: its `gnt` = 1, and `ram_ce` = 1. `ram_we`, `ram_addr`, `ram_write` pass through from the winner. The loser's `gnt` = 0.
- No request → `ram_ce` = 0, `ram_we` = 0; addr/data outputs 0.
- Read grant registers a tag (client, valid). Next cycle, that client's `rvalid` = 1 and its `rdata` = `ram_read`.
  - The other client's `rdata` reads 0.
  - Writes produce no `rvalid`.
- A client may withdraw `req` before grant with no side effect. Changing addr/we/wdata while `req` is held is allowed; the values in the granted cycle are used.
- Any `gnt` is suppressed whenever state ≠ `RUN`.

## Timing
- Grant latency: 0 cycles when uncontested, at most 1 cycle when contested with a continuously requesting peer. A client is never starved.
- Read latency: `rvalid` exactly 1 cycle after the `gnt` cycle. Back-to-back reads give `rvalid` on consecutive cycles. Alternating clients give alternating `rvalid`.
- Read and write to the same address in consecutive cycles: the read returns the new data, since write completes before the read samples.
- Reset values while `rst_n` = 0: all outputs 0 except `busy` = 1. This covers `gnt`, `rvalid`, `rdata` and all `ram_*` outputs.
- Reset mid-operation: an in-flight read tag is discarded, so no `rvalid` after reset. The pointer returns to r1 and the clear counter returns to 0.
- `busy` = 1 in `RST` and `CLEAR`; it drops in the first `RUN` cycle.

## Configuration
- `DPRAM_ARB_CLEAR_EN` defined:
  - `RST` → `CLEAR`. An ADDR_W-bit counter writes 0 to addresses 0 .. 2^ADDR_W−1, one per cycle, with `ram_ce` = `ram_we` = 1.
  - After the write to address 2^ADDR_W−1 (counter wrap), the state moves to `RUN`.
  - `busy` covers 1 + 2^ADDR_W cycles after reset release. Client requests are ignored (no `gnt`) throughout.
- `DPRAM_ARB_CLEAR_EN` not defined:
  - `RST` → `RUN` directly and `busy` is high for 1 cycle after reset release.
  - No counter logic is present and RAM contents are undefined.

## Test plan
- Release reset with the macro off. Expect `busy` = 1 for one cycle. Then `r0_req`, write 0x1234 @ 0x005 → `r0_gnt` = 1 same cycle, with `ram_ce` = `ram_we` = 1, `ram_addr` = 0x005, `ram_write` = 0x1234.
- Read r1 @ 0x005 → `r1_gnt` same cycle, and `r1_rvalid` = 1 with `r1_rdata` = 0x1234 next cycle. `r0_rvalid` stays 0.
- Both clients request reads continuously for 6 cycles → grants r0, r1, r0, r1, r0, r1. Each `rvalid` follows its grant by 1 cycle.
- Assert `rst_n` = 0 in the cycle after an r0 read grant → no `r0_rvalid` and all outputs 0. After release, the first tie is granted to r0.
- Macro on, ADDR_W = 4: release reset → `busy` = 1 for 17 cycles and 16 zero-writes to addresses 0..15, with `r0_req` held high and no `gnt`. A read of 0x3 afterwards returns 0x0000.
- r0 writes 0xBEEF @ 0x2, then r1 reads 0x2 in the next cycle → `r1_rdata` = 0xBEEF.
